// File: rtl/ex_pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX1/EX2/MEM/WB pipeline.
// Handles load-use interlocks, multi-cycle sad in EX2 and EX2 jump squash.
module ex_pipe_hazard_ctrl #(
  parameter int SAD_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       rs_address_ID,
  input  logic [4:0]       rt_address_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic [1:0]       MemRead_EX,
  input  logic [4:0]       RegDst1Result_EX,
  input  logic [1:0]       MemRead_EX2,
  input  logic [4:0]       RegDst1Result_EX2,
  input  logic             sad_EX,
  input  logic             Jump_EX2,
  input  logic             JR_EX2,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX1_Write,
  output logic             IDEX1_Flush,
  output logic             EX1EX2_Write,
  output logic             EX1EX2_Flush,
  output logic             EX2MEM_Flush,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {RUN, SAD_BUSY} state_t;

  localparam logic [3:0] SAD_LOAD =
    4'((SAD_CYCLES > 1) ? (SAD_CYCLES - 2) : 0);

  state_t           state_q, state_d;
  logic [3:0]       sad_cnt_q, sad_cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard_ex1, hazard_ex2;
  logic             load_use, redirect;

  assign hazard_ex1 = (MemRead_EX != 2'd0)
    & (RegDst1Result_EX != 5'd0)
    & ((UsesRs_ID & (rs_address_ID == RegDst1Result_EX))
     | (UsesRt_ID & (rt_address_ID == RegDst1Result_EX)));

  assign hazard_ex2 = (MemRead_EX2 != 2'd0)
    & (RegDst1Result_EX2 != 5'd0)
    & ((UsesRs_ID & (rs_address_ID == RegDst1Result_EX2))
     | (UsesRt_ID & (rt_address_ID == RegDst1Result_EX2)));

  assign load_use = hazard_ex1 | hazard_ex2;
  assign redirect = Jump_EX2 | JR_EX2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RUN;
      sad_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      sad_cnt_q <= sad_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sad_cnt_d    = sad_cnt_q;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX1_Write  = 1'b1;
    IDEX1_Flush  = 1'b0;
    EX1EX2_Write = 1'b1;
    EX1EX2_Flush = 1'b0;
    EX2MEM_Flush = 1'b0;
    Busy         = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          IFID_Flush   = 1'b1;
          IDEX1_Flush  = 1'b1;
          EX1EX2_Flush = 1'b1;
        end else begin
          if (load_use) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX1_Flush = 1'b1;
          end
          // EX1/EX2 still advances under load_use, so the sad moves on
          if (sad_EX && (SAD_CYCLES > 1)) begin
            state_d   = SAD_BUSY;
            sad_cnt_d = SAD_LOAD;
          end
        end
      end
      SAD_BUSY: begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX1_Write  = 1'b0;
        EX1EX2_Write = 1'b0;
        EX2MEM_Flush = 1'b1;
        Busy         = 1'b1;
        if (sad_cnt_q == 4'd0) state_d = RUN;
        else sad_cnt_d = sad_cnt_q - 4'd1;
      end
    endcase
    if (!Reset) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX1_Write  = 1'b0;
      IDEX1_Flush  = 1'b1;
      EX1EX2_Write = 1'b0;
      EX1EX2_Flush = 1'b1;
      EX2MEM_Flush = 1'b1;
      Busy         = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else if (!PCWrite && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_ex_pipe_hazard_ctrl.sv
// Directed bench for ex_pipe_hazard_ctrl.
// Three instances: SAD_CYCLES=4, SAD_CYCLES=1, and CNT_W=4.
module tb_ex_pipe_hazard_ctrl;

  logic       Clk, Reset;
  logic [4:0] rs, rt, d1, d2;
  logic       u_rs, u_rt, sad, jmp, jr;
  logic [1:0] mr1, mr2;

  logic [8:0]  ctl0, ctl1, ctl2;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int n_chk = 0;
  int n_fail = 0;

  // {PCWrite,IFID_W,IFID_F,IDEX1_W,IDEX1_F,EX1EX2_W,EX1EX2_F,EX2MEM_F,Busy}
  localparam logic [8:0] RUN_OK = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] RST    = 9'b0_0_1_0_1_0_1_1_0;
  localparam logic [8:0] STALL  = 9'b0_0_0_1_1_1_0_0_0;
  localparam logic [8:0] JUMP   = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] SADB   = 9'b0_0_0_0_0_0_0_1_1;

  ex_pipe_hazard_ctrl #(.SAD_CYCLES(4), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .rs_address_ID(rs), .rt_address_ID(rt),
    .UsesRs_ID(u_rs), .UsesRt_ID(u_rt),
    .MemRead_EX(mr1), .RegDst1Result_EX(d1),
    .MemRead_EX2(mr2), .RegDst1Result_EX2(d2),
    .sad_EX(sad), .Jump_EX2(jmp), .JR_EX2(jr),
    .PCWrite(ctl0[8]), .IFID_Write(ctl0[7]), .IFID_Flush(ctl0[6]),
    .IDEX1_Write(ctl0[5]), .IDEX1_Flush(ctl0[4]),
    .EX1EX2_Write(ctl0[3]), .EX1EX2_Flush(ctl0[2]),
    .EX2MEM_Flush(ctl0[1]), .Busy(ctl0[0]), .StallCount(sc0)
  );

  ex_pipe_hazard_ctrl #(.SAD_CYCLES(1), .CNT_W(16)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .rs_address_ID(rs), .rt_address_ID(rt),
    .UsesRs_ID(u_rs), .UsesRt_ID(u_rt),
    .MemRead_EX(mr1), .RegDst1Result_EX(d1),
    .MemRead_EX2(mr2), .RegDst1Result_EX2(d2),
    .sad_EX(sad), .Jump_EX2(jmp), .JR_EX2(jr),
    .PCWrite(ctl1[8]), .IFID_Write(ctl1[7]), .IFID_Flush(ctl1[6]),
    .IDEX1_Write(ctl1[5]), .IDEX1_Flush(ctl1[4]),
    .EX1EX2_Write(ctl1[3]), .EX1EX2_Flush(ctl1[2]),
    .EX2MEM_Flush(ctl1[1]), .Busy(ctl1[0]), .StallCount(sc1)
  );

  ex_pipe_hazard_ctrl #(.SAD_CYCLES(4), .CNT_W(4)) u_dut_c (
    .Clk(Clk), .Reset(Reset),
    .rs_address_ID(rs), .rt_address_ID(rt),
    .UsesRs_ID(u_rs), .UsesRt_ID(u_rt),
    .MemRead_EX(mr1), .RegDst1Result_EX(d1),
    .MemRead_EX2(mr2), .RegDst1Result_EX2(d2),
    .sad_EX(sad), .Jump_EX2(jmp), .JR_EX2(jr),
    .PCWrite(ctl2[8]), .IFID_Write(ctl2[7]), .IFID_Flush(ctl2[6]),
    .IDEX1_Write(ctl2[5]), .IDEX1_Flush(ctl2[4]),
    .EX1EX2_Write(ctl2[3]), .EX1EX2_Flush(ctl2[2]),
    .EX2MEM_Flush(ctl2[1]), .Busy(ctl2[0]), .StallCount(sc2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    rs = 0; rt = 0; d1 = 0; d2 = 0;
    u_rs = 0; u_rt = 0; sad = 0; jmp = 0; jr = 0;
    mr1 = 0; mr2 = 0;
  endtask

  initial begin
    clr();
    Reset = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl0), 32'(RST));
    chk("rst_cnt", 32'(sc0), 0);
    repeat (2) tick();
    Reset = 1'b1;
    #1;
    chk("run_idle", 32'(ctl0), 32'(RUN_OK));

    // load in EX1, consumer in ID reads rs
    mr1 = 2'd1; d1 = 5'd5; rs = 5'd5; u_rs = 1; rt = 5'd7; u_rt = 1;
    #1 chk("lu_ex1_c1", 32'(ctl0), 32'(STALL));
    tick();
    mr1 = 0; d1 = 0; mr2 = 2'd1; d2 = 5'd5;
    #1 chk("lu_ex1_c2", 32'(ctl0), 32'(STALL));
    tick();
    mr2 = 0; d2 = 0;
    #1 chk("lu_ex1_done", 32'(ctl0), 32'(RUN_OK));
    chk("lu_ex1_cnt", 32'(sc0), 2);

    // load in EX2 only, rt match
    clr();
    mr2 = 2'd1; d2 = 5'd9; rt = 5'd9; u_rt = 1;
    #1 chk("lu_ex2", 32'(ctl0), 32'(STALL));
    tick();
    clr();
    #1 chk("lu_ex2_done", 32'(ctl0), 32'(RUN_OK));
    chk("lu_ex2_cnt", 32'(sc0), 3);
    mr2 = 2'd1; d2 = 5'd0; rt = 5'd0; u_rt = 1;
    #1 chk("lu_r0", 32'(ctl0), 32'(RUN_OK));
    d2 = 5'd9; rt = 5'd9; u_rt = 0; rs = 5'd9; u_rs = 0;
    #1 chk("lu_nouse", 32'(ctl0), 32'(RUN_OK));
    tick();
    clr();

    // sad occupies EX2 for 4 cycles
    sad = 1;
    #1 chk("sad_c0", 32'(ctl0), 32'(RUN_OK));
    chk("sad1_c0", 32'(ctl1), 32'(RUN_OK));
    tick();
    sad = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("sad_busy%0d", i), 32'(ctl0), 32'(SADB));
      chk($sformatf("sad1_busy%0d", i), 32'(ctl1), 32'(RUN_OK));
      tick();
    end
    #1 chk("sad_end", 32'(ctl0), 32'(RUN_OK));
    chk("sad_cnt", 32'(sc0), 6);

    // redirect beats sad and load_use
    jmp = 1; sad = 1; mr1 = 2'd1; d1 = 5'd5; rs = 5'd5; u_rs = 1;
    #1 chk("jmp", 32'(ctl0), 32'(JUMP));
    tick();
    clr();
    #1 chk("jmp_after", 32'(ctl0), 32'(RUN_OK));
    chk("jmp_cnt", 32'(sc0), 6);
    jr = 1; mr2 = 2'd1; d2 = 5'd3; rt = 5'd3; u_rt = 1;
    #1 chk("jr", 32'(ctl0), 32'(JUMP));
    tick();
    clr();

    // reset during second SAD_BUSY cycle
    sad = 1;
    tick();
    sad = 0;
    #1 chk("rsad_b1", 32'(ctl0), 32'(SADB));
    tick();
    #1 chk("rsad_b2", 32'(ctl0), 32'(SADB));
    chk("rsad_cnt_pre", 32'(sc0), 7);
    Reset = 1'b0;
    #1 chk("rsad_rst", 32'(ctl0), 32'(RST));
    chk("rsad_rst_cnt", 32'(sc0), 0);
    Reset = 1'b1;
    #1 chk("rsad_rel", 32'(ctl0), 32'(RUN_OK));
    tick();
    chk("rsad_run", 32'(ctl0), 32'(RUN_OK));
    chk("rsad_cnt", 32'(sc0), 0);

    // 2^4+3 stall cycles saturate the 4-bit counter
    mr2 = 2'd1; d2 = 5'd9; rt = 5'd9; u_rt = 1;
    repeat (19) tick();
    chk("sat_c", 32'(sc2), 15);
    chk("sat_wide", 32'(sc0), 19);
    repeat (2) tick();
    chk("sat_hold", 32'(sc2), 15);
    clr();
    tick();
    chk("sat_idle", 32'(sc2), 15);
    chk("sat_run", 32'(ctl2), 32'(RUN_OK));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
